load_store_unit: RTL

//  Initiator side of the data_memory port: turns CPU load/store requests (byte address, size, signedness) into

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed CPU requests into doubleword data_memory cycles.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] w_data,
  output logic              ctrl_mem_w,
  output logic              ctrl_mem_r,
  input  logic [DATA_W-1:0] r_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [2:0]          offset_q;
  logic [ADDR_W-1:0]   index_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                trapReq;
  logic [2:0]          reqOffset;
  logic [5:0]          shiftAmt;
  logic [DATA_W-1:0]   shiftedRd;
  logic [DATA_W-1:0]   loadExt;
  logic [DATA_W-1:0]   mergeMask;
  logic [DATA_W-1:0]   merged;
  logic                signBit;
  logic                unusedAddr;

  function automatic logic [2:0] alignMask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] laneMask(input logic [1:0] size);
    case (size)
      2'd0:    return {{(DATA_W-8){1'b0}}, 8'hFF};
      2'd1:    return {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'd2:    return {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: return '1;
    endcase
  endfunction

  // Address bits above the memory window alias and are deliberately dropped.
  assign unusedAddr = ^req_addr[DATA_W-1:ADDR_W+3];

`ifdef LSU_MISALIGN_TRAP_EN
  logic error_q;
  assign trapReq   = |(req_addr[2:0] & alignMask(req_size));
  assign reqOffset = req_addr[2:0];
  assign rsp_error = (state_q == RESP) && error_q;
`else
  assign trapReq   = 1'b0;
  assign reqOffset = req_addr[2:0] & ~alignMask(req_size);
  assign rsp_error = 1'b0;
`endif

  assign shiftAmt  = {offset_q, 3'b000};
  assign shiftedRd = r_data >> shiftAmt;
  assign mergeMask = laneMask(size_q) << shiftAmt;
  assign merged    = (r_data & ~mergeMask) | ((wdata_q << shiftAmt) & mergeMask);

  always_comb begin
    signBit = 1'b0;
    case (size_q)
      2'd0:    signBit = shiftedRd[7];
      2'd1:    signBit = shiftedRd[15];
      2'd2:    signBit = shiftedRd[31];
      default: signBit = 1'b0;
    endcase
    loadExt = shiftedRd & laneMask(size_q);
    if (!unsigned_q && signBit) loadExt = loadExt | ~laneMask(size_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (trapReq)                       state_d = RESP;
          else if (req_we && req_size == 2'd3) state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      offset_q   <= 3'd0;
      index_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q       <= req_we;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        offset_q   <= reqOffset;
        index_q    <= req_addr[ADDR_W+2:3];
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        error_q    <= trapReq;
`endif
      end else if (state_q == CAP) begin
        // r_data is only valid here, so the merge/extract result is captured now.
        if (we_q) wdata_q <= merged;
        else      rdata_q <= loadExt;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign ctrl_mem_r = (state_q == RD);
  assign ctrl_mem_w = (state_q == WR);
  assign address    = (state_q == RD || state_q == WR) ? index_q : '0;
  assign w_data     = (state_q == WR) ? wdata_q : '0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = (state_q == RESP) ? rdata_q : '0;

endmodule
